neuron_integrator: RTL and testbench

Sequential membrane-potential integrator for one neuron per job. It consumes a neuron's stored potential and then streams through every axon of the core, one axon per clock. Each spiking, connected axon adds its axon-type weight with saturation, and a signed leak is applied at the end. The final potential is presented, with a done pulse, to the threshold/reset stage directly downstream, which decides spike and reset.

---
 rtl/neuron_integrator.sv | 161 ++++++++++++++++
 tb/tb_neuron_integrator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_integrator.sv
// -----------------------------------------------------------------------------
// neuron_integrator
//
// Sequential membrane-potential integrator for one neuron per job. A job loads
// the neuron's stored potential, then walks every axon of the core, one per
// clock. Each spiking, connected axon adds the weight of its axon type with
// saturation. A signed leak is applied at the end. The final potential is
// presented with a one-cycle done pulse to the downstream threshold/reset stage.
//
// Ports:
//   clk                - clock; all state changes on its rising edge
//   rst_n              - asynchronous active-low reset
//   start              - begin a job; sampled only while idle
//   potential_in       - signed stored potential, sampled with start
//   weights            - packed signed weights, type k at [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   leak               - signed leak, applied once after the axon scan
//   axon_addr          - registered address of the axon being integrated
//   axon_spike         - spike on axon_addr (same cycle)
//   synapse_connected  - crossbar bit for (axon_addr, this neuron) (same cycle)
//   axon_type          - type of axon_addr, selects the weight (same cycle)
//   busy               - high while a job is in flight
//   done               - one-cycle pulse, potential_out valid
//   potential_out      - signed integrated potential, held until the next done
// -----------------------------------------------------------------------------
module neuron_integrator #(
    parameter int NUM_AXONS       = 256,
    parameter int NUM_WEIGHTS     = 4,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int WEIGHT_WIDTH    = 9,
    parameter int LEAK_WIDTH      = 9
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic signed [POTENTIAL_WIDTH-1:0]     potential_in,
    input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]   weights,
    input  logic signed [LEAK_WIDTH-1:0]          leak,
    output logic [$clog2(NUM_AXONS)-1:0]          axon_addr,
    input  logic                                  axon_spike,
    input  logic                                  synapse_connected,
    input  logic [$clog2(NUM_WEIGHTS)-1:0]        axon_type,
    output logic                                  busy,
    output logic                                  done,
    output logic signed [POTENTIAL_WIDTH-1:0]     potential_out
);

    localparam int ADDR_W = $clog2(NUM_AXONS);

    // Widest operand plus one bit, so a single addition can never wrap before
    // it is clamped.
    localparam int OP_W  = (POTENTIAL_WIDTH > WEIGHT_WIDTH)
                         ? ((POTENTIAL_WIDTH > LEAK_WIDTH) ? POTENTIAL_WIDTH : LEAK_WIDTH)
                         : ((WEIGHT_WIDTH > LEAK_WIDTH) ? WEIGHT_WIDTH : LEAK_WIDTH);
    localparam int SUM_W = OP_W + 1;

    localparam logic [ADDR_W-1:0]                 LAST_ADDR = ADDR_W'(NUM_AXONS - 1);
    localparam logic signed [POTENTIAL_WIDTH-1:0] POT_MAX   = {1'b0, {(POTENTIAL_WIDTH-1){1'b1}}};
    localparam logic signed [POTENTIAL_WIDTH-1:0] POT_MIN   = {1'b1, {(POTENTIAL_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        LEAK,
        DONE
    } state_t;

    state_t                        state, state_next;
    logic signed [POTENTIAL_WIDTH-1:0] acc, acc_next;
    logic signed [POTENTIAL_WIDTH-1:0] pot_out_next;
    logic [ADDR_W-1:0]             addr_next;
    logic signed [WEIGHT_WIDTH-1:0] weight_arr [NUM_WEIGHTS];
    logic signed [POTENTIAL_WIDTH-1:0] leak_sum;

    // Unpack the weight bus so the axon type indexes it directly.
    for (genvar k = 0; k < NUM_WEIGHTS; k++) begin : g_weight
        assign weight_arr[k] = weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // Signed add of two sign-extended operands, clamped to the potential range.
    function automatic logic signed [POTENTIAL_WIDTH-1:0] sat_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b
    );
        logic signed [SUM_W-1:0] s;
        s = a + b;
        if (s > SUM_W'(POT_MAX))
            return POT_MAX;
        else if (s < SUM_W'(POT_MIN))
            return POT_MIN;
        else
            return POTENTIAL_WIDTH'(s);
    endfunction

    assign leak_sum = sat_add(SUM_W'(acc), SUM_W'(leak));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        addr_next    = axon_addr;
        pot_out_next = potential_out;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = potential_in;
                    addr_next  = '0;
                    state_next = INTEGRATE;
                end
            end

            INTEGRATE: begin
                if (axon_spike && synapse_connected)
                    acc_next = sat_add(SUM_W'(acc), SUM_W'(weight_arr[axon_type]));
                if (axon_addr == LAST_ADDR) begin
                    addr_next  = '0;
                    state_next = LEAK;
                end else begin
                    addr_next  = axon_addr + ADDR_W'(1);
                end
            end

            LEAK: begin
                acc_next     = leak_sum;
                pot_out_next = leak_sum;
                state_next   = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            axon_addr     <= '0;
            potential_out <= '0;
        end else begin
            state         <= state_next;
            acc           <= acc_next;
            axon_addr     <= addr_next;
            potential_out <= pot_out_next;
        end
    end

    // done is high exactly for the single cycle spent in DONE, which directly
    // follows the LEAK edge that loaded potential_out.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_neuron_integrator.sv
// -----------------------------------------------------------------------------
// tb_neuron_integrator
//
// Directed bench for neuron_integrator (default parameters). The axon memory is
// modelled as arrays indexed by the DUT's axon_addr. A job-level model computes
// each job's final potential with plain integer arithmetic when start is
// accepted, and predicts busy/done/axon_addr/potential_out from the number of
// edges since that start. A compare process checks all four outputs on every
// falling edge; each job also checks hand-computed literal results and latency.
// -----------------------------------------------------------------------------
module tb_neuron_integrator;

    localparam int N     = 256;
    localparam int P_MAX = 255;
    localparam int P_MIN = -256;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic signed [8:0] potential_in;
    logic [35:0]       weights;
    logic signed [8:0] leak;
    logic [7:0]        axon_addr;
    logic              axon_spike;
    logic              synapse_connected;
    logic [1:0]        axon_type;
    logic              busy;
    logic              done;
    logic signed [8:0] potential_out;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    // Stimulus state: job operands and the axon memory.
    int         w [4];
    int         pin = 0;
    int         lk  = 0;
    logic       sp [N];
    logic       cn [N];
    logic [1:0] ty [N];

    // Job-level model state.
    logic m_active = 1'b0;
    int   m_cnt    = 0;
    int   m_res    = 0;
    int   m_pout   = 0;

    neuron_integrator dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .potential_in      (potential_in),
        .weights           (weights),
        .leak              (leak),
        .axon_addr         (axon_addr),
        .axon_spike        (axon_spike),
        .synapse_connected (synapse_connected),
        .axon_type         (axon_type),
        .busy              (busy),
        .done              (done),
        .potential_out     (potential_out)
    );

    always #5 clk = ~clk;

    assign potential_in      = 9'(pin);
    assign leak              = 9'(lk);
    assign axon_spike        = sp[axon_addr];
    assign synapse_connected = cn[axon_addr];
    assign axon_type         = ty[axon_addr];

    always_comb begin
        weights = '0;
        for (int k = 0; k < 4; k++)
            weights[k*9 +: 9] = w[k][8:0];
    end

    function automatic int clamp(input int v);
        if (v > P_MAX) return P_MAX;
        if (v < P_MIN) return P_MIN;
        return v;
    endfunction

    // Whole-job result: walk the axons in order, clamping after every add.
    function automatic int job_result();
        int a;
        a = pin;
        for (int i = 0; i < N; i++)
            if (sp[i] && cn[i])
                a = clamp(a + w[ty[i]]);
        return clamp(a + lk);
    endfunction

    // Timeline model: m_cnt counts edges since the accepted start edge.
    // busy after edges 0..N+1, done after edge N+1, result visible from N+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_pout   <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
                m_res    <= job_result();
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == N)     m_pout   <= m_res;
            if (m_cnt == N + 1) m_active <= 1'b0;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), (m_active && m_cnt == N + 1) ? 1 : 0);
        check("axon_addr", int'(axon_addr), (m_active && m_cnt < N) ? m_cnt : 0);
        check("potential_out", int'(potential_out), m_pout);
        if (done) done_cnt++;
    end

    task automatic clear_stim();
        for (int k = 0; k < 4; k++) w[k] = 0;
        pin = 0;
        lk  = 0;
        for (int i = 0; i < N; i++) begin
            sp[i] = 1'b0;
            cn[i] = 1'b0;
            ty[i] = 2'd0;
        end
    endtask

    task automatic hit(input int i, input int t);
        sp[i] = 1'b1;
        cn[i] = 1'b1;
        ty[i] = 2'(t);
    endtask

    task automatic setup_basic();
        clear_stim();
        pin  = 10;
        w[0] = 5;
        w[1] = -2;
        lk   = -3;
        hit(0, 0);
        hit(1, 0);
        hit(2, 0);
        hit(7, 1);
    endtask

    // Pulse start, wait (bounded) for done, then check latency, literal result
    // and that exactly one done appeared. Optionally pulses start mid-job.
    task automatic run_job(input string name, input int exp_pout, input bit poke_start);
        int n;
        int d0;
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        while (!done && n < N + 20) begin
            @(negedge clk);
            n++;
            start = poke_start && (n == 50);
        end
        start = 1'b0;
        check({name, " latency"}, n, N + 2);
        check({name, " result"}, int'(potential_out), exp_pout);
        repeat (N + 10) @(negedge clk);
        check({name, " done count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int n;
        int d0;
        clear_stim();

        // Reset held with random inputs.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            pin   = int'($urandom_range(0, 511)) - 256;
            lk    = int'($urandom_range(0, 511)) - 256;
            for (int k = 0; k < 4; k++) w[k] = int'($urandom_range(0, 511)) - 256;
            for (int i = 0; i < N; i++) begin
                sp[i] = 1'($urandom_range(0, 1));
                cn[i] = 1'($urandom_range(0, 1));
                ty[i] = 2'($urandom_range(0, 3));
            end
        end
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset axon_addr", int'(axon_addr), 0);
        check("reset potential_out", int'(potential_out), 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle after reset busy", int'(busy), 0);

        // Basic job: 10 + 5+5+5 - 2 - 3 = 20.
        setup_basic();
        run_job("basic", 20, 1'b0);

        // Positive saturation: clamps at 255, then leak -5.
        clear_stim();
        pin  = 250;
        w[0] = 100;
        lk   = -5;
        for (int i = 0; i < 10; i++) hit(i * 3, 0);
        run_job("pos sat", 250, 1'b0);

        // Negative saturation: clamps at -256, then leak +4.
        clear_stim();
        pin  = -250;
        w[0] = -100;
        lk   = 4;
        hit(20, 0);
        hit(100, 0);
        hit(255, 0);
        run_job("neg sat", -252, 1'b0);

        // Order dependence: 250+100 clamps to 255, then -100 gives 155.
        clear_stim();
        pin  = 250;
        w[0] = 100;
        w[1] = -100;
        hit(0, 0);
        hit(1, 1);
        run_job("order", 155, 1'b0);

        // Masking plus an ignored mid-job start pulse.
        clear_stim();
        pin  = 17;
        w[0] = 50;
        w[2] = -40;
        for (int i = 3; i < 6; i++) sp[i] = 1'b1;
        for (int i = 10; i < 13; i++) begin
            cn[i] = 1'b1;
            ty[i] = 2'd2;
        end
        run_job("masking", 17, 1'b1);

        // Reset mid-job at axon 100.
        setup_basic();
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (axon_addr != 8'd100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("midreset reached addr", int'(axon_addr), 100);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset axon_addr", int'(axon_addr), 0);
        check("midreset potential_out", int'(potential_out), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (N + 10) @(negedge clk);
        check("midreset no done", done_cnt - d0, 0);
        run_job("after reset", 20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
